// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
// HI/LO multiply/divide sequencer for the EX stage. It accepts MULT, MULTU,
// DIV and DIVU. Multiplies wait MUL_LATENCY cycles for the product to settle.
// Divides run a 32-iteration radix-2 restoring divider. While an operation is
// in flight the block requests a pipeline stall. The 64-bit HI/LO result is
// presented with a one-cycle done pulse.

module mult_div_ctrl #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        stall_request,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_LATENCY - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] op1_reg;       // raw multiplicand
  logic [31:0] op2_reg;       // raw multiplier, or |divisor| for divides
  logic        signed_reg;
  logic        neg_q_reg;     // quotient must be negated at the end
  logic        neg_r_reg;     // remainder takes the dividend's sign
  logic [32:0] rem_reg;       // partial remainder
  logic [31:0] quo_reg;       // dividend bits shift out the top, quotient bits in at the bottom
  logic        done_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  // Decode of the incoming instruction
  logic        is_hilo;
  logic        is_div_op;
  logic        is_signed_op;
  logic        accept;
  logic [31:0] op1_abs;
  logic [31:0] op2_abs;

  assign is_hilo      = (funct[5:2] == 4'b0110);
  assign is_div_op    = funct[1];
  assign is_signed_op = ~funct[0];
  assign accept       = (state_reg == IDLE) && en && !flush && is_hilo;

  assign op1_abs = (is_signed_op && operand_1[31]) ? (~operand_1 + 32'd1) : operand_1;
  assign op2_abs = (is_signed_op && operand_2[31]) ? (~operand_2 + 32'd1) : operand_2;

  // Product of the latched operands. Extend each operand to 64 bits; the low
  // 64 bits of the product are then correct for both signed and unsigned.
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] product;

  assign mul_a_ext = {{32{signed_reg & op1_reg[31]}}, op1_reg};
  assign mul_b_ext = {{32{signed_reg & op2_reg[31]}}, op2_reg};
  assign product   = mul_a_ext * mul_b_ext;

  // One restoring-division step: shift in the next dividend bit, then
  // trial-subtract. A clear borrow bit means the subtraction fits.
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        q_bit;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  assign rem_shift = {rem_reg[31:0], quo_reg[31]};
  assign trial     = rem_shift - {1'b0, op2_reg};
  assign q_bit     = ~trial[32];
  assign rem_next  = q_bit ? trial : rem_shift;
  assign quo_next  = {quo_reg[30:0], q_bit};

  // Sign correction applied on the final iteration. For -2^31 / -1 the
  // magnitude quotient is 0x80000000 and it is not negated, which yields the
  // required wrap result.
  assign quo_fixed = neg_q_reg ? (~quo_next + 32'd1) : quo_next;
  assign rem_fixed = neg_r_reg ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];

  // The stall request is combinational so the pipeline freezes in the accept
  // cycle itself. A flush drops it immediately.
  assign stall_request = !flush && (accept || (state_reg == MUL) || (state_reg == DIV));

  assign done      = done_reg;
  assign result_hi = hi_reg;
  assign result_lo = lo_reg;

  // Control FSM, operand latches, divider datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op1_reg    <= '0;
      op2_reg    <= '0;
      signed_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg    <= '0;
            signed_reg <= is_signed_op;
            op1_reg    <= operand_1;
            neg_q_reg  <= is_signed_op && (operand_1[31] ^ operand_2[31]);
            neg_r_reg  <= is_signed_op && operand_1[31];
            rem_reg    <= '0;
            quo_reg    <= op1_abs;
            if (!is_div_op) begin
              op2_reg   <= operand_2;
              state_reg <= MUL;
            end else if (operand_2 == 32'd0) begin
              // Divide by zero finishes at once with a fixed result
              op2_reg   <= operand_2;
              hi_reg    <= operand_1;
              lo_reg    <= 32'hFFFF_FFFF;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              op2_reg   <= op2_abs;
              state_reg <= DIV;
            end
          end
        end

        MUL: begin
          if (cnt_reg == MUL_LAST) begin
            hi_reg    <= product[63:32];
            lo_reg    <= product[31:0];
            done_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end

        DIV: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          if (cnt_reg == DIV_LAST) begin
            hi_reg    <= rem_fixed;
            lo_reg    <= quo_fixed;
            done_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end

        DONE: begin
          // The instruction still sitting in EX is not accepted again here
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl
// Self-checking bench for mult_div_ctrl. It runs directed cases from the test
// plan plus randomized operations, and compares results against a reference
// built on plain 64-bit arithmetic.

module tb_mult_div_ctrl;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        stall_request;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mult_div_ctrl #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .flush         (flush),
    .funct         (funct),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .stall_request (stall_request),
    .done          (done),
    .result_hi     (result_hi),
    .result_lo     (result_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {HI, LO} from ordinary signed/unsigned 64-bit arithmetic
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      sp;
    logic [63:0] up;
    logic [31:0] q;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h18: begin
        sp = sa * sb;
        return sp;
      end
      6'h19: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      6'h1A: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sp = sa / sb;
        q  = sp[31:0];
        sp = sa % sb;
        r  = sp[31:0];
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {r, q};
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [5:0] f, input logic [31:0] b);
    if (!f[1]) return MUL_LAT + 1;
    if (b == 32'd0) return 1;
    return 33;
  endfunction

  // Issue one operation, follow it to done, and check timing and results
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          lat;
    bit          got;
    exp = ref_model(f, a, b);
    @(negedge clk);
    en = 1'b1; funct = f; operand_1 = a; operand_2 = b;
    #1;
    chk("accept_stall", stall_request, 1'b1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
      else chk("busy_stall", stall_request, 1'b1);
    end
    chk("latency", lat, ref_latency(f, b));
    if (got) begin
      chk("done_stall", stall_request, 1'b0);
      chk("hi", result_hi, exp[63:32]);
      chk("lo", result_lo, exp[31:0]);
    end
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    $display("op funct=0x%02h a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d",
             f, a, b, result_hi, result_lo, lat);
  endtask

  // Idle cycles with en low: nothing stalls, no done, and results hold
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0;
      #1;
      chk("idle_stall", stall_request, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("hold_hi", result_hi, last_hi);
      chk("hold_lo", result_lo, last_lo);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0;
    funct = 6'h00; operand_1 = '0; operand_2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_hi", result_hi, 32'd0);
    chk("rst_lo", result_lo, 32'd0);
    chk("rst_stall", stall_request, 1'b0);
    rst = 1'b0;
    $display("reset released");

    // Directed cases from the test plan
    run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_cycles(1);
    run_op(6'h18, 32'hFFFF_FFFD, 32'd5);
    idle_cycles(1);
    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2);
    idle_cycles(1);
    run_op(6'h1B, 32'd100, 32'd7);
    idle_cycles(1);
    run_op(6'h1B, 32'h0000_1234, 32'd0);
    idle_cycles(1);
    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_cycles(1);
    run_op(6'h1A, 32'hFFFF_FFF9, 32'd0);
    idle_cycles(2);

    // Flush in the middle of a divide
    @(negedge clk);
    en = 1'b1; funct = 6'h1B; operand_1 = 32'd1000; operand_2 = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall_request, 1'b0);
    @(negedge clk);
    flush = 1'b0; en = 1'b0;
    #1;
    chk("post_flush_done", done, 1'b0);
    chk("post_flush_hi", result_hi, last_hi);
    chk("post_flush_lo", result_lo, last_lo);
    $display("flush during DIV");
    idle_cycles(40);

    // Reset during a multiply
    run_op(6'h19, 32'd3, 32'd4);
    @(negedge clk);
    en = 1'b1; funct = 6'h19; operand_1 = 32'hDEAD_BEEF; operand_2 = 32'd7;
    repeat (2) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_hi", result_hi, 32'd0);
    chk("mid_rst_lo", result_lo, 32'd0);
    last_hi = '0;
    last_lo = '0;
    $display("reset during MUL");
    idle_cycles(8);

    // Back-to-back: next MULTU issued the cycle after DONE
    run_op(6'h19, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(6'h19, 32'h0001_0000, 32'h0001_0000);
    run_op(6'h1B, 32'hFFFF_FFFF, 32'd10);
    idle_cycles(1);

    // Non-HI/LO function code never stalls
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b1; funct = 6'h21; operand_1 = $urandom; operand_2 = $urandom;
      #1;
      chk("other_funct_stall", stall_request, 1'b0);
      chk("other_funct_done", done, 1'b0);
    end
    $display("funct 0x21 ignored");
    idle_cycles(1);

    // Randomized operations with random gaps
    for (int i = 0; i < 60; i++) begin
      run_op(6'h18 + 6'($urandom_range(0, 3)), pick_operand(), pick_operand());
      idle_cycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Multi-cycle HI/LO arithmetic controller in the EX stage. Accepts MULT/MULTU/DIV/DIVU from the ALU funct stream and sequences a pipelined multiplier delay and an internal 32-iteration radix-2 restoring divider. While an operation is in flight it requests a pipeline stall. It presents the 64-bit HI/LO result for one `done` cycle.

## Interface
- `MUL_LATENCY`, default 4: cycles spent in MUL state; legal range 1–15.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: instruction in EX is valid.
- `flush` input 1: pipeline flush or exception; kills any in-flight operation.
- `funct` input 6: ALU function code. 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU; all other codes are ignored.
- `operand_1` input 32: rs value (dividend or multiplicand).
- `operand_2` input 32: rt value (divisor or multiplier).
- `stall_request` output 1: hold the pipeline; combinational.
- `done` output 1: result valid this cycle; registered.
- `result_hi` output 32: HI result (product[63:32] or remainder); registered.
- `result_lo` output 32: LO result (product[31:0] or quotient); registered.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset puts the block in IDLE with `done`=0, `result_hi`=`result_lo`=0, and counters cleared.
- Accept: in IDLE with `en` && !`flush` && `funct` ∈ {0x18..0x1B}.
  - Latch the operands and the signed flag (0x18, 0x1A).
  - Go to MUL for multiplies.
  - Go to DIV for divides with `operand_2`≠0.
  - Go to DONE for divides with `operand_2`==0.
- MUL:
  - Product is 64-bit; signed uses two's-complement sign extension, unsigned uses zero extension.
  - Counter runs 0..`MUL_LATENCY`-1. On the last count, register the product into HI/LO and go to DONE.
- DIV:
  - Signed ops divide |op1| by |op2| as unsigned.
  - Each cycle shifts one dividend bit into a 33-bit partial remainder, trial-subtracts, and sets a quotient bit.
  - After 32 iterations, fix signs: quotient negated if sign1^sign2, remainder takes sign of op1.
  - Register results and go to DONE.
  - -2^31 / -1 gives LO=0x80000000, HI=0.
- Divide by zero: HI=`operand_1`, LO=0xFFFFFFFF, for both signed and unsigned.
- DONE:
  - `done`=1 for exactly one cycle and `stall_request`=0, so the pipeline advances.
  - Always returns to IDLE. The still-present instruction is not re-accepted in this cycle.
- Results hold their value after DONE until the next accept overwrites them.
- `stall_request` = (IDLE && accept) || MUL || DIV, gated by !`flush`.
- Flush:
  - From any state, go to IDLE next cycle.
  - No `done` is asserted and results are not updated.
  - `stall_request` drops in the flush cycle itself.
- Reset mid-operation: identical to flush, and additionally clears the results to 0.

## Timing
- Accept cycle T: `stall_request`=1.
- Multiply:
  - MUL occupies T+1..T+`MUL_LATENCY`.
  - `done`=1 at T+`MUL_LATENCY`+1.
  - `stall_request`=1 for `MUL_LATENCY`+1 cycles.
- Divide:
  - DIV occupies T+1..T+32.
  - `done` at T+33.
  - 33 stall cycles.
- Divide by zero: `done` at T+1; one stall cycle (T).
- Back-to-back: the earliest next accept is the cycle after DONE.
- `done` and the results are registered. `stall_request` is the only combinational output, depending on state, `en`, `funct` and `flush`.

## Test plan
- Unsigned multiply: MULTU 0xFFFFFFFF × 0xFFFFFFFF, `MUL_LATENCY`=4, accept at T.
  - → `stall_request` high T..T+4; `done` at T+5 with HI=0xFFFFFFFE, LO=0x00000001.
- Signed multiply: MULT 0xFFFFFFFD × 5.
  - → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Signed divide: DIV 0xFFFFFFF9 / 2.
  - → `done` at T+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divide: DIVU 100 / 7.
  - → LO=14, HI=2.
- Divide by zero: DIVU 0x1234 / 0.
  - → `done` at T+1, HI=0x1234, LO=0xFFFFFFFF.
- Flush and reset mid-operation:
  - Assert `flush` at T+10 of a DIV → `stall_request` low at T+10, state IDLE at T+11, no `done`, results unchanged.
  - Assert `rst` during MUL → `done`=0 and results 0 the next cycle.
  - Issue a new MULTU the cycle after DONE → accepted and computed correctly.
  - Non-HI/LO `funct` (e.g. 0x21) → never stalls.
